// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto one shared memory port.
// Define MEM_ARB_RR_EN for round-robin contention; otherwise data side has fixed priority.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_t;

  state_t state, state_nxt;
  logic   i_cand, d_cand, grant_i, grant_d;

`ifdef MEM_ARB_RR_EN
  logic last_grant;  // 0 = fetch side, 1 = data side
`endif

  always_comb begin
    // A side whose done is pulsing is still holding req for the finished access.
    i_cand    = i_req & ~i_done;
    d_cand    = d_req & ~d_done;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    state_nxt = state;
    if (state == IDLE) begin
      if (i_cand && d_cand) begin
`ifdef MEM_ARB_RR_EN
        grant_d = ~last_grant;
        grant_i = last_grant;
`else
        grant_d = 1'b1;
`endif
      end else begin
        grant_i = i_cand;
        grant_d = d_cand;
      end
    end
    case (state)
      IDLE: begin
        if (grant_d)      state_nxt = D_ACC;
        else if (grant_i) state_nxt = I_ACC;
      end
      I_ACC, D_ACC: if (mem_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign mem_req = busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      i_rdata   <= 32'd0;
      d_rdata   <= 32'd0;
`ifdef MEM_ARB_RR_EN
      last_grant <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      i_done <= 1'b0;
      d_done <= 1'b0;
      if (grant_d) begin
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
`ifdef MEM_ARB_RR_EN
        last_grant <= 1'b1;
`endif
      end else if (grant_i) begin
        mem_we    <= 1'b0;
        mem_addr  <= i_addr;
        mem_wdata <= 32'd0;
`ifdef MEM_ARB_RR_EN
        last_grant <= 1'b0;
`endif
      end
      // Command is cleared on completion so the port reads all-zero while idle.
      if (mem_ready && (state == I_ACC || state == D_ACC)) begin
        mem_we    <= 1'b0;
        mem_addr  <= 32'd0;
        mem_wdata <= 32'd0;
        if (state == I_ACC) begin
          i_rdata <= mem_rdata;
          i_done  <= 1'b1;
        end else begin
          if (!mem_we) d_rdata <= mem_rdata;
          d_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

  logic        clk, rst;
  logic        i_req, d_req, d_we, mem_ready;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        i_done, d_done, mem_req, mem_we, busy;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_mem_req"},   {31'd0, mem_req}, 32'd0);
    chk({tag, "_busy"},      {31'd0, busy},    32'd0);
    chk({tag, "_mem_we"},    {31'd0, mem_we},  32'd0);
    chk({tag, "_mem_addr"},  mem_addr,         32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata,        32'd0);
    chk({tag, "_i_done"},    {31'd0, i_done},  32'd0);
    chk({tag, "_d_done"},    {31'd0, d_done},  32'd0);
    chk({tag, "_i_rdata"},   i_rdata,          32'd0);
    chk({tag, "_d_rdata"},   d_rdata,          32'd0);
  endtask

  initial begin
    rst = 1'b1; i_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    tick(); tick();
    chk_idle_zero("reset");
    rst = 1'b0;

    // Lone fetch, zero-wait memory
    i_req = 1; i_addr = 32'h100; mem_ready = 1; mem_rdata = 32'h2402000A;
    chk("f_req_n", {31'd0, mem_req}, 32'd0);
    tick();
    chk("f_req_n1",  {31'd0, mem_req}, 32'd1);
    chk("f_addr_n1", mem_addr, 32'h100);
    chk("f_we_n1",   {31'd0, mem_we}, 32'd0);
    chk("f_busy_n1", {31'd0, busy}, 32'd1);
    chk("f_done_n1", {31'd0, i_done}, 32'd0);
    tick();
    chk("f_done_n2",  {31'd0, i_done}, 32'd1);
    chk("f_rdata_n2", i_rdata, 32'h2402000A);
    chk("f_req_n2",   {31'd0, mem_req}, 32'd0);
    i_req = 0; mem_ready = 0;
    tick();
    chk("f_done_n3", {31'd0, i_done}, 32'd0);
    chk("f_req_n3",  {31'd0, mem_req}, 32'd0);

    // Data write with 3 wait states
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; mem_rdata = 32'h12345678;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("w_req",   {31'd0, mem_req}, 32'd1);
      chk("w_we",    {31'd0, mem_we}, 32'd1);
      chk("w_addr",  mem_addr, 32'h40);
      chk("w_wdata", mem_wdata, 32'hDEADBEEF);
      chk("w_done",  {31'd0, d_done}, 32'd0);
      if (k == 4) mem_ready = 1;
    end
    tick();
    chk("w_done_n5",  {31'd0, d_done}, 32'd1);
    chk("w_rdata_n5", d_rdata, 32'd0);
    d_req = 0; d_we = 0; mem_ready = 0;
    tick();
    chk("w_done_n6", {31'd0, d_done}, 32'd0);
    chk("w_rdata_n6", d_rdata, 32'd0);

    // Contention with both held: D, I, D, I
    i_req = 1; d_req = 1; d_we = 0; i_addr = 32'h200; d_addr = 32'h300; mem_ready = 1;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk("c_req",  {31'd0, mem_req}, 32'd1);
      chk("c_addr", mem_addr, (g % 2 == 0) ? 32'h300 : 32'h200);
      mem_rdata = 32'hA5A50000 | g;
      tick();
      if (g % 2 == 0) begin
        chk("c_d_done",  {31'd0, d_done}, 32'd1);
        chk("c_d_rdata", d_rdata, 32'hA5A50000 | g);
      end else begin
        chk("c_i_done",  {31'd0, i_done}, 32'd1);
        chk("c_i_rdata", i_rdata, 32'hA5A50000 | g);
      end
      if (g == 3) begin i_req = 0; d_req = 0; end
    end
    mem_ready = 0;
    tick();
    chk("c_idle", {31'd0, mem_req}, 32'd0);

    // Policy: first contention goes to D; second fresh contention depends on policy
    i_req = 1; d_req = 1; mem_ready = 1;
    tick();
    chk("p1_addr", mem_addr, 32'h300);
    tick();
    chk("p1_d_done", {31'd0, d_done}, 32'd1);
    i_req = 0; d_req = 0;
    tick();
    chk("p1_idle", {31'd0, mem_req}, 32'd0);
    i_req = 1; d_req = 1;
    tick();
`ifdef MEM_ARB_RR_EN
    chk("p2_addr", mem_addr, 32'h200);
`else
    chk("p2_addr", mem_addr, 32'h300);
`endif
    tick();
    i_req = 0; d_req = 0; mem_ready = 0;
    tick();
    chk("p2_idle", {31'd0, mem_req}, 32'd0);

    // Reset during D_ACC, then a stray mem_ready
    d_req = 1; d_we = 1; d_addr = 32'h44; d_wdata = 32'h55AA55AA;
    tick();
    chk("r_busy", {31'd0, busy}, 32'd1);
    rst = 1;
    tick();
    chk_idle_zero("r_rst");
    rst = 0; d_req = 0; d_we = 0; mem_ready = 1;
    tick();
    chk_idle_zero("r_after");
    mem_ready = 0;

    // Fetch requester drops i_req mid-access
    i_req = 1; i_addr = 32'h500;
    tick();
    chk("x_req",  {31'd0, mem_req}, 32'd1);
    chk("x_addr", mem_addr, 32'h500);
    i_req = 0;
    tick();
    chk("x_req_hold",  {31'd0, mem_req}, 32'd1);
    chk("x_addr_hold", mem_addr, 32'h500);
    mem_ready = 1; mem_rdata = 32'hCAFEF00D;
    tick();
    chk("x_done",  {31'd0, i_done}, 32'd1);
    chk("x_rdata", i_rdata, 32'hCAFEF00D);
    mem_ready = 0;
    tick();
    chk("x_done_once", {31'd0, i_done}, 32'd0);
    chk("x_no_regrant", {31'd0, mem_req}, 32'd0);
    tick();
    chk("x_no_regrant2", {31'd0, mem_req}, 32'd0);
    chk("x_rdata_hold", i_rdata, 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk samples everything on its rising edge; rst is synchronous and active-high.
REQ-002 The block SHALL provide these ports:
- clk  in  1  clock
- rst  in  1  sync active-high reset
- i_req  in  1  fetch-side read request
- i_addr  in  32  fetch address
- i_rdata  out  32  fetch read data
- i_done  out  1  fetch access complete, 1-cycle pulse
- d_req  in  1  data-side request
- d_we  in  1  data-side write enable
- d_addr  in  32  data address
- d_wdata  in  32  data write data
- d_rdata  out  32  data read data
- d_done  out  1  data access complete, 1-cycle pulse
- mem_req  out  1  shared memory request
- mem_we  out  1  shared memory write enable
- mem_addr  out  32  shared memory address
- mem_wdata  out  32  shared memory write data
- mem_rdata  in  32  shared memory read data
- mem_ready  in  1  shared memory completion, valid while mem_req=1
- busy  out  1  access in flight (state != IDLE)

Function
REQ-003 The block SHALL implement an FSM with states IDLE, I_ACC and D_ACC.
REQ-004 In IDLE, candidates SHALL be i_req&~i_done and d_req&~d_done; a requester whose done pulses this cycle is excluded.
REQ-005 In IDLE, a single candidate SHALL be granted; if both are candidates, arbitration follows REQ-013.
REQ-006 On grant the block SHALL latch the command (addr; we=0 for I, d_we for D; wdata=d_wdata for D, 0 for I) and enter the matching ACC state next cycle.
REQ-007 In I_ACC/D_ACC the block SHALL drive mem_req=1 and the latched command, stable until mem_ready=1; no other output changes meanwhile.
REQ-008 On mem_ready=1 in an ACC state, the block SHALL capture mem_rdata into the granted side's rdata register on reads, pulse the granted side's done for exactly 1 cycle next cycle, and return to IDLE.
REQ-009 On D writes, d_rdata SHALL hold its previous value while d_done still pulses.
REQ-010 Timing: minimum latency SHALL be req@N -> mem_req@N+1 -> done@N+2 with zero-wait memory; each wait cycle adds 1; maximum throughput is one access per 2 cycles.
REQ-011 Requesters SHALL hold req and command until done; a req drop mid-access SHALL NOT abort the access, and done still pulses.
REQ-012 mem_ready while not in an ACC state SHALL be ignored; i_rdata and d_rdata hold between accesses.

Configuration
REQ-013 Macro MEM_ARB_RR_EN SHALL select the contention policy:
- Defined: round-robin using a last_grant register (reset value = I); on contention, grant the side not last granted, so the first contention goes to D.
- Undefined: fixed priority, D always wins on contention; last_grant is not built.

Reset
REQ-014 With rst=1 at a clock edge, the block SHALL go to state IDLE and drive mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, i_done=0, d_done=0, i_rdata=0, d_rdata=0, busy=0.
REQ-015 Reset mid-access SHALL abandon the in-flight access with no done pulse; a subsequent mem_ready is ignored per REQ-012.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- Lone fetch: i_req=1, i_addr=0x100, mem_ready=1 on first mem_req cycle, mem_rdata=0x2402000A -> mem_addr=0x100 @N+1, i_done pulse @N+2, i_rdata=0x2402000A.
- Data write with 3 wait states: d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF -> mem_we=1, address/data stable 4 cycles; d_done @N+5; d_rdata unchanged.
- Contention, both req @N:
  - RR undefined: D, then I, then D again while D keeps requesting.
  - RR defined: D, I, D, I.
- Reset asserted during D_ACC, then mem_ready pulsed -> no d_done; IDLE, busy=0, all outputs 0.
- Requester drops i_req mid-I_ACC -> access completes, i_done pulses once, no re-grant.
